// File: rtl/reg_dump_unit.sv
// reg_dump_unit: snapshots the packed 32x32 register bank on request and
// streams it MSB-first, one byte per valid/ready transfer, to the debug UART TX.
// Optional build macro REG_DUMP_CHECKSUM_EN appends one XOR checksum byte
// after the 128 register bytes.
module reg_dump_unit #(
  parameter int unsigned NB_REG  = 32,
  parameter int unsigned N_REGS  = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [N_REGS*NB_REG-1:0] i_registers,
  output logic [NB_BYTE-1:0]       o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned NB_BANK     = N_REGS * NB_REG;
  localparam int unsigned N_BYTES_REG = NB_REG / NB_BYTE;
  localparam int unsigned NB_REG_IDX  = $clog2(N_REGS);
  localparam int unsigned NB_BYTE_IDX = $clog2(N_BYTES_REG);
  localparam logic [NB_REG_IDX-1:0]  LAST_REG  = NB_REG_IDX'(N_REGS - 1);
  localparam logic [NB_BYTE_IDX-1:0] LAST_BYTE = NB_BYTE_IDX'(N_BYTES_REG - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CKSUM = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t                  state;
  // Remaining bytes of the frozen bank; the next byte to offer sits at the top.
  logic [NB_BANK-1:0]      snapshot;
  logic [NB_REG_IDX-1:0]   reg_idx;
  logic [NB_BYTE_IDX-1:0]  byte_idx;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]      cksum;
`endif

  logic xfer_c;
  logic last_byte_c;

  // Handshake completion and final-register-byte detection.
  assign xfer_c      = o_tx_valid & i_tx_ready;
  assign last_byte_c = (reg_idx == LAST_REG) && (byte_idx == LAST_BYTE);

  // Dump sequencer: snapshot capture, byte streaming and completion pulse.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      reg_idx    <= '0;
      byte_idx   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      cksum      <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            // Byte 0 goes straight to the output; the rest is kept pre-shifted.
            snapshot   <= {i_registers[NB_BANK-NB_BYTE-1:0], NB_BYTE'(0)};
            o_tx_data  <= i_registers[NB_BANK-1 -: NB_BYTE];
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            reg_idx    <= '0;
            byte_idx   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
            cksum      <= '0;
`endif
            state      <= SEND;
          end
        end
        SEND: begin
          if (xfer_c) begin
`ifdef REG_DUMP_CHECKSUM_EN
            cksum <= cksum ^ o_tx_data;
`endif
            if (last_byte_c) begin
`ifdef REG_DUMP_CHECKSUM_EN
              o_tx_data <= cksum ^ o_tx_data;
              state     <= CKSUM;
`else
              o_tx_valid <= 1'b0;
              o_done     <= 1'b1;
              state      <= DONE;
`endif
            end else begin
              o_tx_data <= snapshot[NB_BANK-1 -: NB_BYTE];
              snapshot  <= {snapshot[NB_BANK-NB_BYTE-1:0], NB_BYTE'(0)};
              byte_idx  <= byte_idx + NB_BYTE_IDX'(1);
              if (byte_idx == LAST_BYTE) begin
                reg_idx <= reg_idx + NB_REG_IDX'(1);
              end
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CKSUM: begin
          if (xfer_c) begin
            o_tx_valid <= 1'b0;
            o_done     <= 1'b1;
            state      <= DONE;
          end
        end
`endif
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit; expected streams come from a
// register-array model. Honours REG_DUMP_CHECKSUM_EN like the design.
module tb_reg_dump_unit;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int N_BYTES = 129;
`else
  localparam int N_BYTES = 128;
`endif
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1023:0] regs_bus;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_regs [32];

  always #5 clk = ~clk;

  reg_dump_unit dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_registers(regs_bus),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] pack_regs();
    logic [1023:0] bus;
    for (int k = 0; k < 32; k++) bus[(31 - k) * 32 +: 32] = model_regs[k];
    return bus;
  endfunction

  // ready_mode: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random
  task automatic run_dump(input int ready_mode, input bit overwrite, input bit poke_start);
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] cks;
    logic [7:0] prev_data;
    bit         prev_stall;
    int         cyc;
    int         done_cnt;
    int         done_at;
    int         last_x;
    cks = 8'h00;
    for (int k = 0; k < 32; k++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(8'((model_regs[k] >> (24 - 8 * b)) & 32'hFF));
        cks = cks ^ exp_q[exp_q.size() - 1];
      end
    end
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(cks);
`endif
    @(negedge clk);
    regs_bus = pack_regs();
    start    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid", 32'(tx_valid), 32'd1);
    cyc = 0; done_cnt = 0; done_at = -1; last_x = -1;
    prev_stall = 1'b0; prev_data = 8'h00;
    while (cyc < LIMIT) begin
      start = 1'b0;
      if (overwrite) regs_bus = '1;
      if (prev_stall) begin
        check("stall_data_stable", 32'(tx_data), 32'(prev_data));
        check("stall_valid_held", 32'(tx_valid), 32'd1);
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
        check("done_valid_low", 32'(tx_valid), 32'd0);
        check("done_busy_high", 32'(busy), 32'd1);
        if (poke_start) start = 1'b1;
        break;
      end
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke_start && cyc == 20) start = 1'b1;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_x = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      cyc++;
      @(negedge clk);
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    // DONE exit: back to IDLE, any start pulse during DONE ignored.
    @(negedge clk);
    start = 1'b0;
    check("post_done_busy", 32'(busy), 32'd0);
    check("post_done_pulse", 32'(done), 32'd0);
    check("post_done_valid", 32'(tx_valid), 32'd0);
    check("byte_count", 32'(got_q.size()), 32'(N_BYTES));
    for (int i = 0; i < N_BYTES && i < got_q.size(); i++)
      check($sformatf("byte_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("done_after_last", 32'(done_at), 32'(last_x + 1));
    if (ready_mode == 0) check("done_latency", 32'(done_at), 32'(N_BYTES));
  endtask

  task automatic randomize_regs();
    for (int k = 0; k < 32; k++) model_regs[k] = $urandom;
  endtask

  initial begin
    int xfers;
    // Reset held with start asserted: nothing may happen.
    rst_n    = 1'b0;
    start    = 1'b1;
    tx_ready = 1'b1;
    for (int k = 0; k < 32; k++) model_regs[k] = 32'hA5000000 + 32'(k);
    regs_bus = pack_regs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(tx_valid), 32'd0);

    // Directed A5 pattern, ready high then 1,0,0,1 backpressure.
    run_dump(0, 1'b0, 1'b0);
    run_dump(1, 1'b0, 1'b0);

    // Snapshot integrity with bus overwritten every cycle.
    randomize_regs();
    run_dump(0, 1'b1, 1'b0);

    // Start pulses mid-dump and during DONE under random ready.
    randomize_regs();
    run_dump(2, 1'b0, 1'b1);

    // Mid-dump reset after the 50th transfer.
    randomize_regs();
    @(negedge clk);
    regs_bus = pack_regs();
    start    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xfers = 0;
    for (int c = 0; c < LIMIT && xfers < 50; c++) begin
      if (tx_valid && tx_ready) xfers++;
      @(negedge clk);
    end
    check("mid_xfers", 32'(xfers), 32'd50);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    check("mid_rst_done2", 32'(done), 32'd0);
    rst_n = 1'b1;
    randomize_regs();
    run_dump(1, 1'b0, 1'b0);

    // More random traffic.
    randomize_regs();
    run_dump(2, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
